// File: rtl/alu_cdb_arbiter.sv
// Round-robin arbiter that funnels per-lane ALU results onto a single registered CDB broadcast port.
// Optional ALU_CDB_STATS_EN macro adds broadcast/stall counters (bcast_cnt, stall_cnt).
module alu_cdb_arbiter #(
  parameter int SIZE   = 8,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SIZE-1:0]               in_rdy,
  input  logic [SIZE-1:0][TAG_W-1:0]    in_tag,
  input  logic [SIZE-1:0][DATA_W-1:0]   in_data,
  output logic [SIZE-1:0]               accept,
  input  logic                          flush,
  input  logic                          cdb_ready,
`ifdef ALU_CDB_STATS_EN
  output logic [31:0]                   bcast_cnt,
  output logic [31:0]                   stall_cnt,
`endif
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]             cdb_data
);

  // Handshakes: a lane transfer happens on an edge where in_rdy[i] && accept[i];
  // a CDB transfer happens on an edge where cdb_valid && cdb_ready, and the
  // broadcast payload is held stable while cdb_valid && !cdb_ready.

  localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [SIZE-1:0]             occ;
  logic [SIZE-1:0][TAG_W-1:0]  slot_tag;
  logic [SIZE-1:0][DATA_W-1:0] slot_data;
  logic [PTR_W-1:0]            rr_ptr;

  logic [SIZE-1:0]             grant;
  logic [PTR_W-1:0]            gidx;
  logic                        found;
  logic                        load;
  logic [PTR_W-1:0]            rr_next;
  int                          idx;

  assign load = !cdb_valid || cdb_ready;

  // First occupied slot at or after rr_ptr, wrapping SIZE-1 -> 0.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < SIZE; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= SIZE) idx = idx - SIZE;
      if (!found && occ[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    rr_next = '0;
    if (gidx != PTR_W'(SIZE - 1)) rr_next = gidx + PTR_W'(1);
  end

  // A slot being drained into the output stage this edge may be refilled at the same edge.
  always_comb begin
    accept = '0;
    if (rst && !flush) accept = in_rdy & (~occ | (grant & {SIZE{load}}));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ       <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else if (flush) begin
      occ       <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (accept[i])            occ[i] <= 1'b1;
        else if (grant[i] && load) occ[i] <= 1'b0;
      end
      if (load) begin
        if (found) begin
          cdb_valid <= 1'b1;
          cdb_tag   <= slot_tag[gidx];
          cdb_data  <= slot_data[gidx];
          rr_ptr    <= rr_next;
        end else begin
          cdb_valid <= 1'b0;
        end
      end
    end
  end

  // Slot payload is qualified by occ, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) begin
      if (accept[i]) begin
        slot_tag[i]  <= in_tag[i];
        slot_data[i] <= in_data[i];
      end
    end
  end

`ifdef ALU_CDB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcast_cnt <= '0;
      stall_cnt <= '0;
    end else if (cdb_valid) begin
      if (cdb_ready) bcast_cnt <= bcast_cnt + 32'd1;
      else           stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cdb_arbiter.sv
// Self-checking bench for alu_cdb_arbiter: directed scenarios with a scoreboard of expected broadcasts.
module tb_alu_cdb_arbiter;
  localparam int SIZE   = 8;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  logic                        clk;
  logic                        rst;
  logic [SIZE-1:0]             in_rdy;
  logic [SIZE-1:0][TAG_W-1:0]  in_tag;
  logic [SIZE-1:0][DATA_W-1:0] in_data;
  logic [SIZE-1:0]             accept;
  logic                        flush;
  logic                        cdb_ready;
  logic                        cdb_valid;
  logic [TAG_W-1:0]            cdb_tag;
  logic [DATA_W-1:0]           cdb_data;
`ifdef ALU_CDB_STATS_EN
  logic [31:0]                 bcast_cnt;
  logic [31:0]                 stall_cnt;
`endif

  logic [TAG_W+DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  alu_cdb_arbiter #(.SIZE(SIZE), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_rdy(in_rdy), .in_tag(in_tag), .in_data(in_data),
    .accept(accept), .flush(flush), .cdb_ready(cdb_ready),
`ifdef ALU_CDB_STATS_EN
    .bcast_cnt(bcast_cnt), .stall_cnt(stall_cnt),
`endif
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // scoreboard: every completed CDB transfer must match the oldest expected result
  always @(negedge clk) begin
    if (rst && cdb_valid && cdb_ready) begin
      if (exp_q.size() == 0) begin
        check("cdb_unexpected", 64'(1), 64'(0));
      end else begin
        check("cdb_result", 64'({cdb_tag, cdb_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_rdy    = '0;
    flush     = 1'b0;
    cdb_ready = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      in_tag[i]  = '0;
      in_data[i] = '0;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    clear_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input string name, input int max_cycles);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
    step();
  endtask

  task automatic push_lane(input int lane);
    exp_q.push_back({in_tag[lane], in_data[lane]});
  endtask

  initial begin
    // reset state, with all lanes requesting
    rst = 1'b0;
    clear_inputs();
    in_rdy = '1;
    @(negedge clk);
    check("rst_accept", 64'(accept), 64'(0));
    check("rst_valid", 64'(cdb_valid), 64'(0));
    check("rst_tag", 64'(cdb_tag), 64'(0));
    check("rst_data", 64'(cdb_data), 64'(0));
    check("rst_rr_ptr", 64'(dut.rr_ptr), 64'(0));

    // single lane latency
    reset_dut();
    cdb_ready = 1'b1;
    in_rdy = 8'h04; in_tag[2] = 4'd3; in_data[2] = 32'h1234;
    push_lane(2);
    @(negedge clk);
    check("single_accept_c0", 64'(accept), 64'h04);
    step(); in_rdy = '0;
    @(negedge clk);
    check("single_valid_c1", 64'(cdb_valid), 64'(0));
    step();
    @(negedge clk);
    check("single_valid_c2", 64'(cdb_valid), 64'(1));
    check("single_tag_c2", 64'(cdb_tag), 64'(3));
    check("single_data_c2", 64'(cdb_data), 64'h1234);
    step();
    @(negedge clk);
    check("single_valid_c3", 64'(cdb_valid), 64'(0));
    step();

    // all lanes at once: eight back-to-back broadcasts in lane order
    reset_dut();
    cdb_ready = 1'b1;
    in_rdy = '1;
    for (int i = 0; i < SIZE; i++) begin
      in_tag[i] = TAG_W'(i);
      in_data[i] = $urandom;
      push_lane(i);
    end
    @(negedge clk);
    check("all_accept", 64'(accept), 64'hFF);
    step(); in_rdy = '0;
    step();
    for (int k = 0; k < SIZE; k++) begin
      @(negedge clk);
      check("all_back_to_back", 64'(cdb_valid), 64'(1));
      step();
    end
    @(negedge clk);
    check("all_idle_after", 64'(cdb_valid), 64'(0));
    check("all_rr_ptr", 64'(dut.rr_ptr), 64'(0));
    drain("all_drain", 4);

    // back-pressure: output stage stuck, lanes 1 and 5 full
    reset_dut();
    in_rdy = 8'h01; in_tag[0] = 4'hA; in_data[0] = $urandom;
    push_lane(0);
    @(negedge clk);
    check("bp_accept_l0", 64'(accept), 64'h01);
    step();
    in_rdy = 8'h22;
    in_tag[1] = 4'd1; in_data[1] = $urandom;
    in_tag[5] = 4'd5; in_data[5] = $urandom;
    push_lane(1); push_lane(5);
    @(negedge clk);
    check("bp_accept_fill", 64'(accept), 64'h22);
    step();
    in_tag[1] = 4'd9; in_data[1] = $urandom;
    in_tag[5] = 4'hD; in_data[5] = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_accept_blocked", 64'(accept), 64'(0));
      check("bp_valid_held", 64'(cdb_valid), 64'(1));
      check("bp_tag_held", 64'(cdb_tag), 64'hA);
      check("bp_data_held", 64'({cdb_tag, cdb_data}), 64'(exp_q[0]));
      step();
    end
    in_rdy = '0; cdb_ready = 1'b1;
    drain("bp_drain", 10);

    // fairness: lanes 0 and 3 continuously requesting
    reset_dut();
    cdb_ready = 1'b1;
    in_tag[0] = 4'd0; in_data[0] = 32'h0000_A0A0;
    in_tag[3] = 4'd3; in_data[3] = 32'h0003_B3B3;
    for (int k = 0; k < 13; k++) push_lane((k % 2 == 0) ? 0 : 3);
    in_rdy = 8'h09;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("fair_accept", 64'(accept), (k == 0) ? 64'h09 : ((k % 2 == 1) ? 64'h01 : 64'h08));
      step();
    end
    in_rdy = '0;
    drain("fair_drain", 10);

    // flush with three slots occupied and a stalled broadcast
    reset_dut();
    in_rdy = 8'h01; in_tag[0] = 4'd7; in_data[0] = $urandom;
    step();
    in_rdy = 8'h0E;
    for (int i = 1; i < 4; i++) begin
      in_tag[i] = TAG_W'(i + 4); in_data[i] = $urandom;
    end
    step();
    flush = 1'b1; in_rdy = 8'h01;
    @(negedge clk);
    check("flush_pre_valid", 64'(cdb_valid), 64'(1));
    check("flush_accept", 64'(accept), 64'(0));
    step();
    flush = 1'b0; in_rdy = '0; cdb_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("flush_no_bcast", 64'(cdb_valid), 64'(0));
      step();
    end

    // asynchronous reset in the middle of a burst
    reset_dut();
    cdb_ready = 1'b1;
    in_rdy = '1;
    for (int i = 0; i < SIZE; i++) begin
      in_tag[i] = TAG_W'(i + 8);
      in_data[i] = $urandom;
      push_lane(i);
    end
    step(); in_rdy = '0;
    repeat (3) step();
    @(negedge clk);
    #2;
    in_rdy = '1;
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(cdb_valid), 64'(0));
    check("arst_tag", 64'(cdb_tag), 64'(0));
    check("arst_accept", 64'(accept), 64'(0));
    exp_q.delete();
    step();
    rst = 1'b1; in_rdy = '0;
`ifdef ALU_CDB_STATS_EN
    check("arst_bcast_cnt", 64'(bcast_cnt), 64'(0));
    check("arst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    in_rdy = 8'h40; in_tag[6] = 4'd6; in_data[6] = $urandom;
    push_lane(6);
    @(negedge clk);
    check("resume_accept", 64'(accept), 64'h40);
    step(); in_rdy = '0;
    drain("resume_drain", 6);
`ifdef ALU_CDB_STATS_EN
    check("resume_bcast_cnt", 64'(bcast_cnt), 64'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
